frame_stage_sequencer: RTL and testbench
========================================

Name: frame_stage_sequencer

Overview:
- Runs the per-frame image-processing stages in a fixed order (edge detection, followed by later stages) over one shared single-port frame RAM.
- Each stage uses the existing enable/done level handshake and drives its own wren, address and data_write.
- The sequencer enables one stage at a time and waits for its done. It then releases the stage and muxes the active stage's memory port onto the RAM.
- Sits between the top-level frame controller (start/busy/frame_done) and the stage blocks.

Parameters:
NUM_STAGES, 4, number of stage slots; slot 0 runs first.
ADDR_W, 18, RAM address width.
DATA_W, 32, RAM data width.
WDT_W, 24, watchdog counter width (WATCHDOG_EN only).
WDT_LIMIT, 24'hFFFFFF, max cycles a stage may stay in RUN before abort (WATCHDOG_EN only).

Ports:
clk  in  1  system clock, all state on rising edge.
reset_n  in  1  asynchronous active-low reset.
pause  in  1  global pause; freezes the sequencer.
start  in  1  single-cycle request to process one frame.
stage_mask  in  NUM_STAGES  1 = stage runs this frame; sampled when start is accepted.
busy  out  1  high from the cycle after start is accepted until FINISH.
frame_done  out  1  one-cycle pulse when the frame completes.
active_stage  out  $clog2(NUM_STAGES)  index of the slot being selected or run.
stage_enable  out  NUM_STAGES  one-hot (or zero) enable to stages.
stage_done  in  NUM_STAGES  done levels from stages.
stage_wren  in  NUM_STAGES  per-stage write enables.
stage_address  in  NUM_STAGES*ADDR_W  packed per-stage addresses; slot i at [i*ADDR_W +: ADDR_W].
stage_data_write  in  NUM_STAGES*DATA_W  packed per-stage write data.
stage_data_read  out  DATA_W  ram_data_read broadcast unchanged to all stages.
ram_wren  out  1  RAM write enable.
ram_address  out  ADDR_W  RAM address.
ram_data_write  out  DATA_W  RAM write data.
ram_data_read  in  DATA_W  RAM read data.
timeout_error  out  1  sticky watchdog abort flag (WATCHDOG_EN only).

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, idx=0, mask register=0.
  - busy=0, frame_done=0, stage_enable=0, active_stage=0, timeout_error=0.
  - RAM outputs: ram_wren=0, ram_address=0, ram_data_write=0.
  - Reset mid-frame drops the enable immediately; the stage sees enable=0 and self-clears.
- States: IDLE, SELECT, RUN, RELEASE, FINISH.
- IDLE:
  - start=1 and pause=0 → latch stage_mask, idx=0, busy=1, go to SELECT.
  - start while busy=1 is ignored; it is not queued.
- SELECT (one cycle per slot):
  - idx==NUM_STAGES → FINISH.
  - mask[idx]=0 → idx+1, stay in SELECT.
  - mask[idx]=1 → RUN.
- RUN:
  - stage_enable[idx]=1.
  - stage_done[idx]=1 → RELEASE; enable drops on the same edge.
- RELEASE:
  - enable=0; wait for stage_done[idx]=0, then idx+1 → SELECT.
  - If done is already low, exit after one cycle.
- FINISH: frame_done=1 for exactly one cycle, busy=0, → IDLE.
- RAM mux (combinational from the registered idx and state, zero added latency):
  - In RUN or RELEASE, ram_* = slot idx's port.
  - Otherwise ram_wren=0, ram_address=0, ram_data_write=0.
  - stage_wren from non-active slots is never forwarded.
- Pause:
  - State, idx and watchdog hold.
  - stage_enable is held unchanged, and ram_wren is forced to 0.
  - A start that arrives during pause is dropped.
- Timing example: all-zero mask gives frame_done NUM_STAGES+2 cycles after the start edge (1 IDLE→SELECT, NUM_STAGES SELECT cycles, 1 FINISH).
- Widths: active_stage = idx truncated; idx is $clog2(NUM_STAGES)+1 bits so it can reach NUM_STAGES.

Optional Feature:
- Macro: FRAME_SEQ_WATCHDOG_EN.
- Defined:
  - Counter clears on RUN entry and increments each unpaused RUN cycle.
  - At WDT_LIMIT: enable drops, timeout_error=1 (sticky until reset), state → FINISH. frame_done still pulses.
  - The aborted stage is not retried.
- Undefined: no counter; timeout_error is tied 0; RUN waits indefinitely.

Test Plan:
- mask=4'b0001, stage 0 raises done 10 cycles after enable, drops 1 cycle after enable falls → enable[0] high 10 cycles, frame_done one pulse, busy then 0.
- mask=4'b1010 → stage 1 enabled then stage 3 only; enable never overlaps; slots 0/2 never see enable.
- Active slot 1 drives wren=1/address=18'd2240/data=1 while slot 0 drives wren=1 → RAM sees only slot 1 values; ram_wren=0 in SELECT/IDLE.
- pause=1 for 5 cycles in RUN with stage_wren=1 → ram_wren=0 during pause, state held, resumes same stage; start during pause ignored.
- reset_n low mid-RUN → all outputs reset asynchronously; next start runs from slot 0; mask=0 gives frame_done 6 cycles after start (NUM_STAGES=4).
- WATCHDOG_EN, WDT_LIMIT=100, stage never raises done → enable drops after 100 RUN cycles, timeout_error=1, frame_done pulses.

Source files
------------

// File: rtl/frame_stage_sequencer.sv
// Frame stage sequencer: runs enabled stage slots in order over one shared RAM port.
// Optional watchdog abort is built when FRAME_SEQ_WATCHDOG_EN is defined.
module frame_stage_sequencer #(
    parameter int               NUM_STAGES = 4,
    parameter int               ADDR_W     = 18,
    parameter int               DATA_W     = 32,
    parameter int               WDT_W      = 24,
    parameter logic [WDT_W-1:0] WDT_LIMIT  = 24'hFFFFFF
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           pause,
    input  logic                           start,
    input  logic [NUM_STAGES-1:0]          stage_mask,
    output logic                           busy,
    output logic                           frame_done,
    output logic [$clog2(NUM_STAGES)-1:0]  active_stage,
    output logic [NUM_STAGES-1:0]          stage_enable,
    input  logic [NUM_STAGES-1:0]          stage_done,
    input  logic [NUM_STAGES-1:0]          stage_wren,
    input  logic [NUM_STAGES*ADDR_W-1:0]   stage_address,
    input  logic [NUM_STAGES*DATA_W-1:0]   stage_data_write,
    output logic [DATA_W-1:0]              stage_data_read,
    output logic                           ram_wren,
    output logic [ADDR_W-1:0]              ram_address,
    output logic [DATA_W-1:0]              ram_data_write,
    input  logic [DATA_W-1:0]              ram_data_read,
    output logic                           timeout_error
);

    localparam int AS_W  = $clog2(NUM_STAGES);
    localparam int IDX_W = AS_W + 1;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SELECT  = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RELEASE = 3'd3;
    localparam logic [2:0] ST_FINISH  = 3'd4;

    localparam logic [IDX_W-1:0]      IDX_ONE   = {{(IDX_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0]      IDX_END   = IDX_W'(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    logic [2:0]            state_r, state_s;
    logic [IDX_W-1:0]      idx_r, idx_s;
    logic [NUM_STAGES-1:0] mask_r, mask_s;
    logic [NUM_STAGES-1:0] enable_r, enable_s;
    logic                  busy_r, busy_s;
    logic                  frame_done_r, frame_done_s;
    logic [AS_W-1:0]       slot_s;

`ifdef FRAME_SEQ_WATCHDOG_EN
    localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};
    logic [WDT_W-1:0] wdt_r, wdt_s;
    logic             timeout_r, timeout_s;
`else
    logic unused_wdt_cfg_s;
    assign unused_wdt_cfg_s = ^WDT_LIMIT;
`endif

    // idx can reach NUM_STAGES; slot_s is only meaningful below that.
    assign slot_s = idx_r[AS_W-1:0];

    // Next-state and next-output decode; a paused sequencer holds everything.
    always_comb begin
        state_s      = state_r;
        idx_s        = idx_r;
        mask_s       = mask_r;
        enable_s     = enable_r;
        busy_s       = busy_r;
        frame_done_s = 1'b0;
`ifdef FRAME_SEQ_WATCHDOG_EN
        wdt_s        = wdt_r;
        timeout_s    = timeout_r;
`endif
        if (pause) begin
            state_s = state_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mask_s  = stage_mask;
                        idx_s   = {IDX_W{1'b0}};
                        busy_s  = 1'b1;
                        state_s = ST_SELECT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (idx_r == IDX_END) begin
                        state_s = ST_FINISH;
                    end else if (mask_r[slot_s]) begin
                        enable_s = STAGE_ONE << slot_s;
                        state_s  = ST_RUN;
`ifdef FRAME_SEQ_WATCHDOG_EN
                        wdt_s    = {WDT_W{1'b0}};
`endif
                    end else begin
                        idx_s = idx_r + IDX_ONE;
                    end
                end
                ST_RUN: begin
                    if (stage_done[slot_s]) begin
                        enable_s = {NUM_STAGES{1'b0}};
                        state_s  = ST_RELEASE;
                    end else begin
`ifdef FRAME_SEQ_WATCHDOG_EN
                        // Abort after WDT_LIMIT RUN cycles; the stage is not retried.
                        if (wdt_r == WDT_LIMIT - WDT_ONE) begin
                            enable_s  = {NUM_STAGES{1'b0}};
                            timeout_s = 1'b1;
                            state_s   = ST_FINISH;
                        end else begin
                            wdt_s = wdt_r + WDT_ONE;
                        end
`else
                        state_s = ST_RUN;
`endif
                    end
                end
                ST_RELEASE: begin
                    if (!stage_done[slot_s]) begin
                        idx_s   = idx_r + IDX_ONE;
                        state_s = ST_SELECT;
                    end else begin
                        state_s = ST_RELEASE;
                    end
                end
                ST_FINISH: begin
                    busy_s       = 1'b0;
                    frame_done_s = 1'b1;
                    state_s      = ST_IDLE;
                end
                default: begin
                    state_s  = ST_IDLE;
                    idx_s    = {IDX_W{1'b0}};
                    enable_s = {NUM_STAGES{1'b0}};
                    busy_s   = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_W{1'b0}};
            mask_r       <= {NUM_STAGES{1'b0}};
            enable_r     <= {NUM_STAGES{1'b0}};
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            mask_r       <= mask_s;
            enable_r     <= enable_s;
            busy_r       <= busy_s;
            frame_done_r <= frame_done_s;
        end
    end

`ifdef FRAME_SEQ_WATCHDOG_EN
    // Watchdog counter and sticky abort flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wdt_r     <= {WDT_W{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            wdt_r     <= wdt_s;
            timeout_r <= timeout_s;
        end
    end

    assign timeout_error = timeout_r;
`else
    assign timeout_error = 1'b0;
`endif

    // Only the slot being run or released owns the RAM port; pause blocks writes.
    always_comb begin
        ram_wren       = 1'b0;
        ram_address    = {ADDR_W{1'b0}};
        ram_data_write = {DATA_W{1'b0}};
        if ((state_r == ST_RUN) || (state_r == ST_RELEASE)) begin
            ram_wren       = stage_wren[slot_s] & ~pause;
            ram_address    = stage_address[slot_s*ADDR_W +: ADDR_W];
            ram_data_write = stage_data_write[slot_s*DATA_W +: DATA_W];
        end else begin
            ram_wren       = 1'b0;
            ram_address    = {ADDR_W{1'b0}};
            ram_data_write = {DATA_W{1'b0}};
        end
    end

    assign stage_data_read = ram_data_read;
    assign busy            = busy_r;
    assign frame_done      = frame_done_r;
    assign stage_enable    = enable_r;
    assign active_stage    = idx_r[AS_W-1:0];

endmodule

// File: tb/tb_frame_stage_sequencer.sv
// Self-checking bench for frame_stage_sequencer: vector table, hand sequences, random frames.
// Watchdog checks are compiled in when FRAME_SEQ_WATCHDOG_EN is defined.
module tb_frame_stage_sequencer;

    localparam int N  = 4;
    localparam int AW = 18;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset_n, pause, start;
    logic [N-1:0]      stage_mask, stage_enable, stage_done, stage_wren;
    logic              busy, frame_done, ram_wren, timeout_error;
    logic [1:0]        active_stage;
    logic [N*AW-1:0]   stage_address;
    logic [N*DW-1:0]   stage_data_write;
    logic [DW-1:0]     stage_data_read, ram_data_write, ram_data_read;
    logic [AW-1:0]     ram_address;

    frame_stage_sequencer #(
        .NUM_STAGES(N), .ADDR_W(AW), .DATA_W(DW), .WDT_W(24), .WDT_LIMIT(24'd100)
    ) dut (
        .clk(clk), .reset_n(reset_n), .pause(pause), .start(start),
        .stage_mask(stage_mask), .busy(busy), .frame_done(frame_done),
        .active_stage(active_stage), .stage_enable(stage_enable),
        .stage_done(stage_done), .stage_wren(stage_wren),
        .stage_address(stage_address), .stage_data_write(stage_data_write),
        .stage_data_read(stage_data_read), .ram_wren(ram_wren),
        .ram_address(ram_address), .ram_data_write(ram_data_write),
        .ram_data_read(ram_data_read), .timeout_error(timeout_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] mask;
        int           lat;
        int           exp_cycles;
    } vec_t;

    int           n_chk = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           fd_count = 0;
    int           lat[N];
    int           en_cnt[N];
    bit           rand_bus = 1'b1;
    logic [N-1:0] prev_en = '0;
    int           runs_slot[$];
    int           runs_len[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock: observe at the falling edge, then update stage models and bus stimulus.
    task automatic tick();
        int k;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        k = -1;
        for (int i = 0; i < N; i++) if (stage_enable[i]) k = i;
        if (k >= 0) begin
            chk("enable_onehot", $countones(stage_enable), 1);
            chk("ram_wren_mux", ram_wren, pause ? 1'b0 : stage_wren[k]);
            chk("ram_addr_mux", ram_address, stage_address[k*AW +: AW]);
            chk("ram_data_mux", ram_data_write, stage_data_write[k*DW +: DW]);
            if (prev_en == '0) begin
                runs_slot.push_back(k);
                runs_len.push_back(1);
            end else begin
                runs_len[runs_len.size()-1] = runs_len[runs_len.size()-1] + 1;
            end
        end else if (!busy) begin
            chk("ram_idle_wren", ram_wren, 1'b0);
            chk("ram_idle_addr", ram_address, '0);
        end
        chk("data_read_bcast", stage_data_read, ram_data_read);
        if (frame_done) fd_count++;
        prev_en = stage_enable;
        for (int i = 0; i < N; i++) begin
            if (stage_enable[i]) begin
                en_cnt[i]++;
                if (en_cnt[i] >= lat[i]) stage_done[i] = 1'b1;
            end else begin
                en_cnt[i]     = 0;
                stage_done[i] = 1'b0;
            end
        end
        if (rand_bus) begin
            stage_wren = N'($urandom);
            for (int i = 0; i < N; i++) begin
                stage_address[i*AW +: AW]    = AW'($urandom);
                stage_data_write[i*DW +: DW] = $urandom;
            end
            ram_data_read = $urandom;
        end
    endtask

    task automatic run_frame(input logic [N-1:0] m, output int took);
        int t0;
        runs_slot.delete();
        runs_len.delete();
        fd_count   = 0;
        stage_mask = m;
        start      = 1'b1;
        tick();
        start = 1'b0;
        t0    = cyc;
        chk("busy_on_start", busy, 1'b1);
        while (fd_count == 0 && (cyc - t0) < 3000) tick();
        took = cyc - t0;
        chk("frame_done_seen", fd_count, 1);
        tick();
        chk("frame_done_pulse", frame_done, 1'b0);
        chk("busy_after_frame", busy, 1'b0);
    endtask

    // Expected run order is the set mask bits ascending, each run lasting its stage latency.
    task automatic check_frame(input logic [N-1:0] m, input int took, input int exp_took);
        int exp_slots[$];
        for (int i = 0; i < N; i++) if (m[i]) exp_slots.push_back(i);
        chk("frame_cycles", took, exp_took);
        chk("run_count", runs_slot.size(), exp_slots.size());
        for (int j = 0; j < exp_slots.size() && j < runs_slot.size(); j++) begin
            chk("run_slot", runs_slot[j], exp_slots[j]);
            chk("run_len", runs_len[j], lat[exp_slots[j]]);
        end
        chk("timeout_clear", timeout_error, 1'b0);
    endtask

    initial begin
        vec_t tbl[6];
        int   took, exp, t0;

        tbl[0] = '{4'b0001, 10, 17};
        tbl[1] = '{4'b1010,  3, 14};
        tbl[2] = '{4'b0000,  1,  6};
        tbl[3] = '{4'b1111,  1, 14};
        tbl[4] = '{4'b0100,  5, 12};
        tbl[5] = '{4'b1000,  2,  9};

        reset_n = 1'b1; pause = 1'b0; start = 1'b0; stage_mask = '0;
        stage_done = '0; stage_wren = '1; stage_address = '1; stage_data_write = '1;
        ram_data_read = '0;
        for (int i = 0; i < N; i++) begin lat[i] = 1; en_cnt[i] = 0; end
        #1 reset_n = 1'b0;
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_enable", stage_enable, '0);
        chk("rst_active", active_stage, 2'd0);
        chk("rst_ram_wren", ram_wren, 1'b0);
        chk("rst_ram_addr", ram_address, '0);
        chk("rst_ram_data", ram_data_write, '0);
        chk("rst_timeout", timeout_error, 1'b0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < N; i++) lat[i] = tbl[v].lat;
            run_frame(tbl[v].mask, took);
            check_frame(tbl[v].mask, took, tbl[v].exp_cycles);
        end

        // Mux isolation, then pause in RUN with a start that must be dropped.
        rand_bus = 1'b0;
        for (int i = 0; i < N; i++) lat[i] = 30;
        stage_wren = 4'b1111;
        stage_address = '0; stage_data_write = '0;
        stage_address[0*AW +: AW] = 18'd7;    stage_data_write[0*DW +: DW] = 32'hDEAD_BEEF;
        stage_address[1*AW +: AW] = 18'd2240; stage_data_write[1*DW +: DW] = 32'd1;
        runs_slot.delete(); runs_len.delete(); fd_count = 0;
        stage_mask = 4'b0010; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ram_select_wren", ram_wren, 1'b0);
        tick();
        chk("ram_select_wren2", ram_wren, 1'b0);
        repeat (2) tick();
        chk("mux_enable", stage_enable, 4'b0010);
        chk("mux_wren", ram_wren, 1'b1);
        chk("mux_addr", ram_address, 18'd2240);
        chk("mux_data", ram_data_write, 32'd1);
        stage_wren = 4'b0001;
        #1 chk("mux_no_foreign_wren", ram_wren, 1'b0);
        stage_wren = 4'b1111;
        pause = 1'b1; start = 1'b1;
        for (int p = 0; p < 5; p++) begin
            tick();
            chk("pause_wren", ram_wren, 1'b0);
            chk("pause_enable", stage_enable, 4'b0010);
            chk("pause_active", active_stage, 2'd1);
        end
        pause = 1'b0; start = 1'b0;
        t0 = cyc;
        while (fd_count == 0 && (cyc - t0) < 3000) tick();
        tick();
        chk("pause_frame_done", fd_count, 1);
        chk("pause_run_count", runs_slot.size(), 1);
        chk("pause_run_len", runs_len.size() > 0 ? runs_len[0] : 0, 30);
        chk("pause_busy_after", busy, 1'b0);
        pause = 1'b1; start = 1'b1;
        tick();
        pause = 1'b0; start = 1'b0;
        tick();
        chk("paused_start_dropped", busy, 1'b0);

        // Asynchronous reset in the middle of RUN.
        lat[0] = 50;
        stage_mask = 4'b0001; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_enable", stage_enable, 4'b0001);
        reset_n = 1'b0;
        #1;
        chk("midrst_enable", stage_enable, '0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_active", active_stage, 2'd0);
        chk("midrst_ram_wren", ram_wren, 1'b0);
        chk("midrst_ram_addr", ram_address, '0);
        chk("midrst_frame_done", frame_done, 1'b0);
        #1 reset_n = 1'b1;
        prev_en = '0;
        rand_bus = 1'b1;
        tick();
        run_frame(4'b0000, took);
        check_frame(4'b0000, took, 6);
        for (int i = 0; i < N; i++) lat[i] = 2;
        run_frame(4'b1111, took);
        check_frame(4'b1111, took, 6 + 4 * 3);

        // Random frames against the cycle/order model.
        for (int r = 0; r < 25; r++) begin
            logic [N-1:0] m;
            m   = N'($urandom_range(0, 15));
            exp = N + 2;
            for (int i = 0; i < N; i++) begin
                lat[i] = $urandom_range(1, 8);
                if (m[i]) exp = exp + lat[i] + 1;
            end
            run_frame(m, took);
            check_frame(m, took, exp);
        end

`ifdef FRAME_SEQ_WATCHDOG_EN
        lat[0] = 100000;
        run_frame(4'b0001, took);
        chk("wdt_cycles", took, 102);
        chk("wdt_run_len", runs_len.size() > 0 ? runs_len[0] : 0, 100);
        chk("wdt_flag", timeout_error, 1'b1);
        tick();
        chk("wdt_sticky", timeout_error, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
